// File: rtl/seg_scan_decoder.sv
// Recovers four mm:ss values from a multiplexed active-low 7-segment scan bus.
// Samples are debounced per dwell, decoded per slot and assembled into frames.
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       Resetn,
  input  logic [7:0] AN,
  input  logic [7:0] CX,
  input  logic       clr_err,
  output logic [5:0] alarm_min,
  output logic [5:0] alarm_sec,
  output logic [5:0] clock_min,
  output logic [5:0] clock_sec,
  output logic [7:0] dp_mask,
  output logic       frame_valid,
  output logic       match,
  output logic       seg_err,
  output logic       scan_err,
  output logic       range_err
);

  localparam logic       COLLECT    = 1'b0;
  localparam logic       ASSEMBLE   = 1'b1;
  localparam logic [3:0] CNT_COMMIT = 4'(SETTLE - 1);
  localparam logic [3:0] CNT_MAX    = 4'(SETTLE);

  // {legal, digit}; anything outside the ten digit patterns is illegal
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      default:    return 5'b0;
    endcase
  endfunction

  function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({2'b00, tens} * 6'd10) + {2'b00, units};
  endfunction

  logic [7:0] an_p0, cx_p0, an_p1, cx_p1;
  logic       vld_p0, vld_p1;
  logic [3:0] cnt;
  logic [3:0] digit [8];
  logic [7:0] seen, seen_nx, set_bit, lows;
  logic       state;
  logic [2:0] slot_idx;
  logic [4:0] dec;
  logic       commit, onehot, blank, wr_en, seg_evt, scan_evt, range_evt, tens_ok;
  logic [5:0] amin_n, asec_n, cmin_n, csec_n;

  // Commit stage: works on the previous sample, which the counter has proven stable
  always_comb begin
    lows     = ~an_p1;
    blank    = (lows == 8'h00);
    onehot   = $onehot(lows);
    slot_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (lows[7-i]) slot_idx = 3'(i);
    dec      = seg_decode(cx_p1[7:1]);
    commit   = (cnt == CNT_COMMIT);
    wr_en    = commit & onehot & dec[4];
    seg_evt  = commit & onehot & ~dec[4];
    scan_evt = commit & ~blank & ~onehot;
    set_bit  = wr_en ? (8'h01 << slot_idx) : 8'h00;
    seen_nx  = ((state == ASSEMBLE) ? 8'h00 : seen) | set_bit;
    tens_ok  = (digit[0] <= 4'd5) && (digit[2] <= 4'd5) &&
               (digit[4] <= 4'd5) && (digit[6] <= 4'd5);
    range_evt = (state == ASSEMBLE) & ~tens_ok;
    amin_n   = bcd2bin(digit[0], digit[1]);
    asec_n   = bcd2bin(digit[2], digit[3]);
    cmin_n   = bcd2bin(digit[4], digit[5]);
    csec_n   = bcd2bin(digit[6], digit[7]);
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      an_p0 <= '0; cx_p0 <= '0; vld_p0 <= 1'b0;
      an_p1 <= '0; cx_p1 <= '0; vld_p1 <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < 8; i++) digit[i] <= '0;
      seen <= '0; dp_mask <= '0; state <= COLLECT;
      alarm_min <= '0; alarm_sec <= '0; clock_min <= '0; clock_sec <= '0;
      frame_valid <= 1'b0; match <= 1'b0;
      seg_err <= 1'b0; scan_err <= 1'b0; range_err <= 1'b0;
    end else begin
      // Sample stage, then the stability counter on sample vs previous sample
      an_p0 <= AN; cx_p0 <= CX; vld_p0 <= 1'b1;
      an_p1 <= an_p0; cx_p1 <= cx_p0; vld_p1 <= vld_p0;
      if (!vld_p1 || an_p0 != an_p1 || cx_p0 != cx_p1) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 4'd1;

      if (wr_en) begin
        digit[slot_idx]   <= dec[3:0];
        dp_mask[slot_idx] <= ~cx_p1[0];
      end
      seen <= seen_nx;

      // Frame stage: one ASSEMBLE cycle after the last slot is seen
      case (state)
        COLLECT:  if (seen_nx == 8'hFF) state <= ASSEMBLE;
        default:  state <= COLLECT;
      endcase
      frame_valid <= 1'b0;
      if (state == ASSEMBLE && tens_ok) begin
        alarm_min   <= amin_n;
        alarm_sec   <= asec_n;
        clock_min   <= cmin_n;
        clock_sec   <= csec_n;
        match       <= (cmin_n == amin_n) && (csec_n == asec_n);
        frame_valid <= 1'b1;
      end

      seg_err   <= (seg_err   & ~clr_err) | seg_evt;
      scan_err  <= (scan_err  & ~clr_err) | scan_evt;
      range_err <= (range_err & ~clr_err) | range_evt;
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter: SETTLE, 4, consecutive identical registered scan samples needed to accept a digit (legal range 2..15).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 AN  input  8  digit-enable scan, active-low, AN[7] = slot 0 ... AN[0] = slot 7.
REQ-005 CX  input  8  segments active-low, CX[7:1] = a..g, CX[0] = decimal point.
REQ-006 clr_err  input  1  synchronous clear of sticky error flags.
REQ-007 alarm_min, alarm_sec, clock_min, clock_sec  output  6 each  reconstructed binary values, 0..59.
REQ-008 dp_mask  output  8  decimal-point state per slot, 1 = lit, bit i = slot i.
REQ-009 frame_valid  output  1  one-cycle pulse when all four output values update.
REQ-010 match  output  1  registered flag, 1 when clock_min==alarm_min and clock_sec==alarm_sec.
REQ-011 seg_err, scan_err, range_err  output  1 each  sticky error flags.

Function
REQ-012 AN and CX SHALL be registered once, and all decoding SHALL use these registered samples.
REQ-013 Stability counter: clears to 0 when the sample differs from the previous sample, otherwise increments, saturating at SETTLE.
REQ-014 Commit: one commit per dwell, when the counter reaches SETTLE-1; with AN/CX held from edge t, the slot register updates at edge t+SETTLE+1.
REQ-015 Slot selection: exactly one AN bit low selects that slot; AN=8'hFF is blank and is ignored without error; two or more low bits at commit set scan_err and write nothing.
REQ-016 Segment decode of CX[7:1]:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
REQ-017 On a commit with a legal code: write the 4-bit digit to the slot, set the slot's seen bit, and set dp_mask[slot] = ~CX[0].
REQ-018 On a commit with an illegal code: set seg_err and leave the digit register and seen bit unchanged.
REQ-019 Slot map:
  - 0/1 = alarm_min tens/units
  - 2/3 = alarm_sec tens/units
  - 4/5 = clock_min tens/units
  - 6/7 = clock_sec tens/units
REQ-020 Frame FSM states: COLLECT, then ASSEMBLE. COLLECT goes to ASSEMBLE on the edge at which the eighth seen bit becomes set.
REQ-021 ASSEMBLE lasts exactly one cycle, then returns to COLLECT with all seen bits cleared.
REQ-022 In ASSEMBLE with all four tens digits <=5: value = tens*10 + units (6-bit) for all four outputs, frame_valid=1, and match updated from the new values, all on the same edge.
REQ-023 In ASSEMBLE with any tens digit >5: set range_err, leave outputs and match unchanged, and keep frame_valid=0.
REQ-024 Re-committing an already-seen slot before the frame completes SHALL overwrite that digit and not advance the frame.
REQ-025 Sticky flags clear on clr_err; when an error event and clr_err occur in the same cycle, the flag SHALL be set.
REQ-026 A scan counter wrap (slot 7 back to slot 0) needs no special handling; frames are defined only by seen bits.

Reset
REQ-027 While Resetn=0, all outputs, digit registers, seen bits, dp_mask, the stability counter and the sample registers SHALL be 0, and the FSM SHALL be in COLLECT.
REQ-028 Deassertion takes effect at the next clk edge; an asynchronous assertion mid-frame SHALL discard all partial-frame content.

Verification
REQ-029 Eight slots driven for 20 cycles each with digits 1,2,3,4,1,2,3,4, no dp -> one frame_valid; alarm_min=12, alarm_sec=34, clock_min=12, clock_sec=34, match=1, no errors.
REQ-030 Slot 0 with CX=8'b0000001_0 held for exactly SETTLE-1 cycles, then changed -> no commit; held for SETTLE cycles -> commit at edge t+SETTLE+1 with digit 0 and dp_mask[0]=1.
REQ-031 Slot 3 with CX[7:1]=1111111 -> seg_err=1 and no frame. Re-driving slot 3 with a legal code completes the frame. clr_err -> seg_err=0.
REQ-032 AN=8'b00111111 held -> scan_err=1. AN=8'hFF held 50 cycles -> no commit and no error.
REQ-033 Full frame with clock_sec tens = 7 -> range_err=1, frame_valid stays 0, and previous outputs are retained.
REQ-034 Resetn pulsed low after 5 slots committed, then a full frame of 5,9,5,9,0,0,0,1 -> a single frame_valid with alarm 59:59 and clock 00:01, match=0.
